// File: rtl/egg_timer_ctrl_if.sv
// Command and display bundle between a front panel (master) and the egg timer controller (slave).
// Commands are single-cycle pulses; display outputs are registered by the controller.
interface egg_timer_ctrl_if;
    logic       tick_in;
    logic       start_in;
    logic       stop_in;
    logic       clear_in;
    logic       inc_min_in;
    logic       inc_sec_in;
    logic [5:0] min_out;
    logic [5:0] sec_out;
    logic [1:0] state_out;
    logic       alarm_en_out;
    logic       done_out;

    modport master (
        output tick_in, start_in, stop_in, clear_in, inc_min_in, inc_sec_in,
        input  min_out, sec_out, state_out, alarm_en_out, done_out
    );

    modport slave (
        input  tick_in, start_in, stop_in, clear_in, inc_min_in, inc_sec_in,
        output min_out, sec_out, state_out, alarm_en_out, done_out
    );
endinterface

// File: rtl/egg_timer_ctrl.sv
// Kitchen egg timer: minutes/seconds set in IDLE, 1 Hz countdown in RUN, pause, and a
// timed ALARM phase that returns to IDLE on its own or on any run-control command.
module egg_timer_ctrl #(
    parameter int MAX_MIN     = 59,
    parameter int ALARM_TICKS = 10
) (
    input  logic             clk_in,
    input  logic             rst_in,
    egg_timer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_e;

    localparam int         CNT_W     = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [5:0] MAX_MIN_L = 6'(MAX_MIN);
    localparam logic [5:0] MAX_SEC_L = 6'd59;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_TICKS - 1);

    state_e           state_q;
    logic [5:0]       min_q;
    logic [5:0]       sec_q;
    logic             alarm_en_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            min_q      <= '0;
            sec_q      <= '0;
            alarm_en_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clear_in) begin
                        min_q <= '0;
                        sec_q <= '0;
                    end else if (bus.stop_in) begin
                        // stop outranks the increments, so it simply swallows them here
                    end else if (bus.start_in) begin
                        if ((min_q != '0) || (sec_q != '0)) state_q <= RUN;
                    end else begin
                        if (bus.inc_min_in) min_q <= (min_q >= MAX_MIN_L) ? '0 : min_q + 6'd1;
                        if (bus.inc_sec_in) sec_q <= (sec_q >= MAX_SEC_L) ? '0 : sec_q + 6'd1;
                    end
                end
                RUN: begin
                    if (bus.clear_in) begin
                        state_q <= IDLE;
                        min_q   <= '0;
                        sec_q   <= '0;
                    end else if (bus.stop_in) begin
                        state_q <= PAUSE;
                    end else if (bus.tick_in) begin
                        if (sec_q != '0) begin
                            sec_q <= sec_q - 6'd1;
                            if ((min_q == '0) && (sec_q == 6'd1)) begin
                                state_q    <= ALARM;
                                alarm_en_q <= 1'b1;
                                done_q     <= 1'b1;
                                cnt_q      <= '0;
                            end
                        end else begin
                            min_q <= min_q - 6'd1;
                            sec_q <= MAX_SEC_L;
                        end
                    end
                end
                PAUSE: begin
                    if (bus.clear_in || bus.stop_in) begin
                        state_q <= IDLE;
                        min_q   <= '0;
                        sec_q   <= '0;
                    end else if (bus.start_in) begin
                        state_q <= RUN;
                    end
                end
                ALARM: begin
                    if (bus.clear_in || bus.stop_in || bus.start_in) begin
                        state_q    <= IDLE;
                        alarm_en_q <= 1'b0;
                        min_q      <= '0;
                        sec_q      <= '0;
                    end else if (bus.tick_in) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q    <= IDLE;
                            alarm_en_q <= 1'b0;
                            min_q      <= '0;
                            sec_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    alarm_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.min_out      = min_q;
    assign bus.sec_out      = sec_q;
    assign bus.state_out    = state_q;
    assign bus.alarm_en_out = alarm_en_q;
    assign bus.done_out     = done_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Scenario bench for egg_timer_ctrl: each task lays out command pulses with the display
// state expected after that edge; expectations queue up as commands go in and are popped per edge.
module tb_egg_timer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    egg_timer_ctrl_if bus();

    egg_timer_ctrl #(.MAX_MIN(59), .ALARM_TICKS(10)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    localparam logic [6:0] RST   = 7'd1;
    localparam logic [6:0] TICK  = 7'd2;
    localparam logic [6:0] START = 7'd4;
    localparam logic [6:0] STOP  = 7'd8;
    localparam logic [6:0] CLR   = 7'd16;
    localparam logic [6:0] IM    = 7'd32;
    localparam logic [6:0] IS    = 7'd64;
    localparam logic [6:0] NONE  = 7'd0;

    typedef struct packed {
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] st;
        logic       al;
        logic       dn;
    } snap_t;

    typedef struct packed {
        logic [6:0] c;
        snap_t      e;
    } step_t;

    snap_t exp_q[$];
    step_t plan[$];
    int    vectors     = 0;
    int    miscompares = 0;

    function automatic snap_t S(input int m, input int s, input int st, input logic al, input logic dn);
        snap_t r;
        r.m  = 6'(m);
        r.s  = 6'(s);
        r.st = 2'(st);
        r.al = al;
        r.dn = dn;
        return r;
    endfunction

    function automatic snap_t snap();
        snap_t r;
        r.m  = bus.min_out;
        r.s  = bus.sec_out;
        r.st = bus.state_out;
        r.al = bus.alarm_en_out;
        r.dn = bus.done_out;
        return r;
    endfunction

    function automatic string fmt(input snap_t x);
        return $sformatf("%0d:%0d st=%0d al=%0b dn=%0b", x.m, x.s, x.st, x.al, x.dn);
    endfunction

    function automatic void add(input logic [6:0] c, input snap_t e);
        step_t t;
        t.c = c;
        t.e = e;
        plan.push_back(t);
    endfunction

    task automatic drive(input logic [6:0] c, input snap_t e);
        exp_q.push_back(e);
        rst            = c[0];
        bus.tick_in    = c[1];
        bus.start_in   = c[2];
        bus.stop_in    = c[3];
        bus.clear_in   = c[4];
        bus.inc_min_in = c[5];
        bus.inc_sec_in = c[6];
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.tick_in    = 1'b0;
        bus.start_in   = 1'b0;
        bus.stop_in    = 1'b0;
        bus.clear_in   = 1'b0;
        bus.inc_min_in = 1'b0;
        bus.inc_sec_in = 1'b0;
    endtask

    task automatic test_reset();
        snap_t e, got;
        plan.delete();
        add(RST, S(0, 0, 0, 0, 0));
        add(IS, S(0, 1, 0, 0, 0));
        add(IM, S(1, 1, 0, 0, 0));
        add(RST | IM | IS | START, S(0, 0, 0, 0, 0));
        add(NONE, S(0, 0, 0, 0, 0));
        foreach (plan[i]) begin
            drive(plan[i].c, plan[i].e);
            e = exp_q.pop_front();
            got = snap();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_countdown();
        snap_t e, got;
        plan.delete();
        add(RST, S(0, 0, 0, 0, 0));
        for (int k = 1; k <= 3; k++) add(IS, S(0, k, 0, 0, 0));
        add(START, S(0, 3, 1, 0, 0));
        add(NONE,  S(0, 3, 1, 0, 0));
        add(TICK,  S(0, 2, 1, 0, 0));
        add(TICK,  S(0, 1, 1, 0, 0));
        add(TICK,  S(0, 0, 3, 1, 1));
        add(NONE,  S(0, 0, 3, 1, 0));
        add(NONE,  S(0, 0, 3, 1, 0));
        add(CLR,   S(0, 0, 0, 0, 0));
        foreach (plan[i]) begin
            drive(plan[i].c, plan[i].e);
            e = exp_q.pop_front();
            got = snap();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL countdown[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_pause();
        snap_t e, got;
        plan.delete();
        add(RST,          S(0, 0, 0, 0, 0));
        add(IM,           S(1, 0, 0, 0, 0));
        add(START,        S(1, 0, 1, 0, 0));
        add(TICK,         S(0, 59, 1, 0, 0));
        add(TICK | STOP,  S(0, 59, 2, 0, 0));
        add(TICK,         S(0, 59, 2, 0, 0));
        add(IS | IM,      S(0, 59, 2, 0, 0));
        add(START | TICK, S(0, 59, 1, 0, 0));
        add(TICK,         S(0, 58, 1, 0, 0));
        add(IS | IM,      S(0, 58, 1, 0, 0));
        add(STOP,         S(0, 58, 2, 0, 0));
        add(STOP,         S(0, 0, 0, 0, 0));
        foreach (plan[i]) begin
            drive(plan[i].c, plan[i].e);
            e = exp_q.pop_front();
            got = snap();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL pause[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_set_wrap();
        snap_t e, got;
        plan.delete();
        add(RST,   S(0, 0, 0, 0, 0));
        add(START, S(0, 0, 0, 0, 0));
        for (int k = 1; k <= 60; k++) add(IS, S(0, k % 60, 0, 0, 0));
        for (int k = 1; k <= 60; k++) add(IM, S(k % 60, 0, 0, 0, 0));
        add(IM | IS,   S(1, 1, 0, 0, 0));
        add(STOP | IM, S(1, 1, 0, 0, 0));
        add(TICK,      S(1, 1, 0, 0, 0));
        add(CLR | IS,  S(0, 0, 0, 0, 0));
        foreach (plan[i]) begin
            drive(plan[i].c, plan[i].e);
            e = exp_q.pop_front();
            got = snap();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL set_wrap[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_alarm_timeout();
        snap_t e, got;
        plan.delete();
        add(RST,   S(0, 0, 0, 0, 0));
        add(IS,    S(0, 1, 0, 0, 0));
        add(START, S(0, 1, 1, 0, 0));
        add(TICK,  S(0, 0, 3, 1, 1));
        for (int k = 1; k <= 9; k++) begin
            add(TICK, S(0, 0, 3, 1, 0));
            add(NONE, S(0, 0, 3, 1, 0));
        end
        add(TICK,  S(0, 0, 0, 0, 0));
        // second run: stop after four alarm ticks
        add(IS,    S(0, 1, 0, 0, 0));
        add(IS,    S(0, 2, 0, 0, 0));
        add(START, S(0, 2, 1, 0, 0));
        add(TICK,  S(0, 1, 1, 0, 0));
        add(TICK,  S(0, 0, 3, 1, 1));
        for (int k = 1; k <= 4; k++) add(TICK, S(0, 0, 3, 1, 0));
        add(STOP,  S(0, 0, 0, 0, 0));
        // third run: counter must restart from zero, so nine ticks keep ALARM
        add(IS,    S(0, 1, 0, 0, 0));
        add(START, S(0, 1, 1, 0, 0));
        add(TICK,  S(0, 0, 3, 1, 1));
        for (int k = 1; k <= 9; k++) add(TICK, S(0, 0, 3, 1, 0));
        add(START | TICK, S(0, 0, 0, 0, 0));
        add(NONE,  S(0, 0, 0, 0, 0));
        foreach (plan[i]) begin
            drive(plan[i].c, plan[i].e);
            e = exp_q.pop_front();
            got = snap();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL alarm_timeout[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    task automatic test_clear_reset();
        snap_t e, got;
        plan.delete();
        add(RST, S(0, 0, 0, 0, 0));
        for (int k = 1; k <= 30; k++) add(IS, S(0, k, 0, 0, 0));
        add(START,      S(0, 30, 1, 0, 0));
        add(CLR | STOP, S(0, 0, 0, 0, 0));
        add(IS,         S(0, 1, 0, 0, 0));
        add(START,      S(0, 1, 1, 0, 0));
        add(TICK,       S(0, 0, 3, 1, 1));
        add(TICK,       S(0, 0, 3, 1, 0));
        add(RST | TICK, S(0, 0, 0, 0, 0));
        add(NONE,       S(0, 0, 0, 0, 0));
        add(IM,         S(1, 0, 0, 0, 0));
        add(IS,         S(1, 1, 0, 0, 0));
        add(START,      S(1, 1, 1, 0, 0));
        add(TICK,       S(1, 0, 1, 0, 0));
        add(TICK,       S(0, 59, 1, 0, 0));
        add(RST | TICK, S(0, 0, 0, 0, 0));
        add(TICK,       S(0, 0, 0, 0, 0));
        add(IS,         S(0, 1, 0, 0, 0));
        add(START,      S(0, 1, 1, 0, 0));
        add(STOP,       S(0, 1, 2, 0, 0));
        add(CLR,        S(0, 0, 0, 0, 0));
        foreach (plan[i]) begin
            drive(plan[i].c, plan[i].e);
            e = exp_q.pop_front();
            got = snap();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL clear_reset[%0d] got %s want %s", i, fmt(got), fmt(e));
            end
        end
    endtask

    initial begin
        bus.tick_in    = 1'b0;
        bus.start_in   = 1'b0;
        bus.stop_in    = 1'b0;
        bus.clear_in   = 1'b0;
        bus.inc_min_in = 1'b0;
        bus.inc_sec_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_countdown();
        test_pause();
        test_set_wrap();
        test_alarm_timeout();
        test_clear_reset();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
